boot_ctrl: RTL and testbench

Sequencer that brings up the single-cycle RV32I core for a run. It holds the core in reset and streams a program image into instruction and data memory. It then zeroes the reserved data words, releases the core, and watches for the completion flag write (0xFF to byte 0xfffc) or a watchdog expiry. It owns the data-memory write port except while the core is running, when it passes the core's store signals through.

---
 rtl/boot_pkg.sv | 22 ++
 rtl/boot_watchdog.sv | 31 +++
 rtl/boot_ctrl.sv | 160 ++++++++++++++++
 tb/tb_boot_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared constants for the boot sequencer: FSM encodings, INIT scrub
// addresses and load/flag constants.
package boot_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_INIT    = 3'd2;
  localparam state_t ST_RUN     = 3'd3;
  localparam state_t ST_DONE    = 3'd4;
  localparam state_t ST_TIMEOUT = 3'd5;

  // Reserved data words zeroed before the core starts, in write order.
  localparam logic [0:4][15:0] INIT_ADDRS = {16'h9078, 16'h907c, 16'h9080, 16'h9084, 16'hfffc};
  localparam logic [2:0]       INIT_LAST  = 3'd4;

  localparam logic [7:0]  DONE_BYTE = 8'hFF;
  localparam logic [15:0] WORD_STEP = 16'd4;
  localparam logic [15:0] LAST_PTR  = 16'hfffc;

endpackage

// File: rtl/boot_watchdog.sv
// Saturating cycle counter used to bound how long the core may run.
module boot_watchdog #(
  parameter int MAX = 100000,
  parameter int W   = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         expired
);

  localparam logic [W-1:0] LIM = W'(MAX - 1);
  localparam logic [W-1:0] SAT = W'(MAX);
  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != SAT)) begin
      cnt <= cnt + ONE;
    end
  end

  // Fires during the last permitted RUN cycle so the FSM leaves on that edge.
  assign expired = en && (cnt == LIM);

endmodule

// File: rtl/boot_ctrl.sv
// Boot sequencer: loads a program image, scrubs reserved words, runs the
// core and watches for the completion flag or a watchdog expiry.
module boot_ctrl #(
  parameter logic [15:0] DONE_ADDR = 16'hfffc,
  parameter int          WDOG_MAX  = 100000,
  parameter int          WDOG_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              im_we,
  output logic [15:0]       im_addr,
  output logic [31:0]       im_wdata,
  input  logic [3:0]        cpu_dm_we,
  input  logic [15:0]       cpu_dm_addr,
  input  logic [31:0]       cpu_dm_wdata,
  output logic [3:0]        dm_we,
  output logic [15:0]       dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [WDOG_W-1:0] wdog_cnt
);

  import boot_pkg::*;

  state_t      state;
  logic [15:0] ptr;
  logic [2:0]  idx;
  logic        xfer;
  logic        done_det;
  logic        restart;
  logic        wd_clr;
  logic        wd_en;
  logic        wd_expired;

  assign xfer     = (state == ST_LOAD) && ld_valid;
  assign done_det = (state == ST_RUN) && (cpu_dm_addr == DONE_ADDR) &&
                    cpu_dm_we[0] && (cpu_dm_wdata[7:0] == DONE_BYTE);
  assign restart  = start && ((state == ST_DONE) || (state == ST_TIMEOUT));
  assign wd_clr   = (state == ST_IDLE) || restart;
  assign wd_en    = (state == ST_RUN);

  boot_watchdog #(.MAX(WDOG_MAX), .W(WDOG_W)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .cnt     (wdog_cnt),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      idx      <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ptr      <= '0;
          idx      <= '0;
          done     <= 1'b0;
          timeout  <= 1'b0;
          overflow <= 1'b0;
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          // The top word is forced to be the last one so ptr never wraps.
          if (xfer) begin
            if (ld_last || (ptr == LAST_PTR)) begin
              state    <= ST_INIT;
              overflow <= (ptr == LAST_PTR) && !ld_last;
            end else begin
              ptr <= ptr + WORD_STEP;
            end
          end
        end
        ST_INIT: begin
          if (idx == INIT_LAST) begin
            idx   <= '0;
            state <= ST_RUN;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        ST_RUN: begin
          if (done_det) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (wd_expired) begin
            state   <= ST_TIMEOUT;
            timeout <= 1'b1;
          end
        end
        ST_DONE, ST_TIMEOUT: begin
          if (start) begin
            state    <= ST_LOAD;
            ptr      <= '0;
            idx      <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            overflow <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory write ports are combinational so the word lands on the accepting edge.
  always_comb begin
    ld_ready = 1'b0;
    im_we    = 1'b0;
    im_addr  = '0;
    im_wdata = '0;
    dm_we    = '0;
    dm_addr  = '0;
    dm_wdata = '0;
    cpu_rst  = 1'b1;
    busy     = 1'b0;
    case (state)
      ST_LOAD: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        im_we    = xfer;
        im_addr  = ptr;
        im_wdata = ld_data;
        dm_we    = {4{xfer}};
        dm_addr  = ptr;
        dm_wdata = ld_data;
      end
      ST_INIT: begin
        busy     = 1'b1;
        dm_we    = 4'hF;
        dm_addr  = INIT_ADDRS[idx];
        dm_wdata = 32'h0;
      end
      ST_RUN: begin
        busy     = 1'b1;
        cpu_rst  = 1'b0;
        dm_we    = cpu_dm_we;
        dm_addr  = cpu_dm_addr;
        dm_wdata = cpu_dm_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// Scoreboard bench for boot_ctrl: expected memory writes are queued by the
// stimulus tasks and matched by a negedge monitor; status is checked directly.
module tb_boot_ctrl;

  localparam int WMAX = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = 32'h0;
  logic        ld_last = 1'b0;
  logic        im_we;
  logic [15:0] im_addr;
  logic [31:0] im_wdata;
  logic [3:0]  cpu_dm_we = 4'h0;
  logic [15:0] cpu_dm_addr = 16'h0;
  logic [31:0] cpu_dm_wdata = 32'h0;
  logic [3:0]  dm_we;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        overflow;
  logic [16:0] wdog_cnt;

  typedef struct packed {
    logic        imwe;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expq[$];
  wr_t         monw;
  logic        monok;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] mptr = 16'h0;

  boot_ctrl #(.DONE_ADDR(16'hfffc), .WDOG_MAX(WMAX), .WDOG_W(17)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_dm_we    (cpu_dm_we),
    .cpu_dm_addr  (cpu_dm_addr),
    .cpu_dm_wdata (cpu_dm_wdata),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .overflow     (overflow),
    .wdog_cnt     (wdog_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushWrite(input logic imwe, input logic [3:0] we, input logic [15:0] addr,
                           input logic [31:0] data);
    wr_t w;
    w.imwe = imwe;
    w.we   = we;
    w.addr = addr;
    w.data = data;
    expq.push_back(w);
  endtask

  task automatic pushInit;
    pushWrite(1'b0, 4'hF, 16'h9078, 32'h0);
    pushWrite(1'b0, 4'hF, 16'h907c, 32'h0);
    pushWrite(1'b0, 4'hF, 16'h9080, 32'h0);
    pushWrite(1'b0, 4'hF, 16'h9084, 32'h0);
    pushWrite(1'b0, 4'hF, 16'hfffc, 32'h0);
  endtask

  task automatic pulseStart;
    start = 1'b1;
    mptr  = 16'h0;
    tick;
    start = 1'b0;
  endtask

  // One load-port cycle; an accepted word is expected at the modelled pointer.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l);
    ld_valid = v;
    ld_data  = d;
    ld_last  = l;
    if (v) begin
      pushWrite(1'b1, 4'hF, mptr, d);
      if (mptr != 16'hfffc) mptr = mptr + 16'd4;
    end
    tick;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 32'hdeadbeef;
  endtask

  task automatic applyStore(input logic [3:0] we, input logic [15:0] addr, input logic [31:0] data);
    cpu_dm_we    = we;
    cpu_dm_addr  = addr;
    cpu_dm_wdata = data;
    if (we != 4'h0) pushWrite(1'b0, we, addr, data);
    tick;
    cpu_dm_we    = 4'h0;
    cpu_dm_addr  = 16'h0;
    cpu_dm_wdata = 32'h0;
  endtask

  always @(negedge clk) begin
    if (im_we || (dm_we != 4'h0)) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected write: im_we=%0b dm_we=0x%0h addr=0x%0h data=0x%0h, required none",
                 im_we, dm_we, dm_addr, dm_wdata);
      end else begin
        monw  = expq.pop_front();
        monok = (im_we == monw.imwe) && (dm_we == monw.we) && (dm_addr == monw.addr) &&
                (dm_wdata == monw.data) &&
                (!im_we || ((im_addr == dm_addr) && (im_wdata == dm_wdata)));
        if (!monok) begin
          errors++;
          $display("[TB] FAIL mem write: got im_we=%0b im_addr=0x%0h im_wdata=0x%0h dm_we=0x%0h dm_addr=0x%0h dm_wdata=0x%0h, expected im_we=%0b we=0x%0h addr=0x%0h data=0x%0h",
                   im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata,
                   monw.imwe, monw.we, monw.addr, monw.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global time limit: simulation still running, expected completion");
    $fatal(1, "[TB] time limit expired");
  end

  initial begin
    #2 rst = 1'b1;
    tick;
    tick;
    checkOutput("reset cpu_rst", cpu_rst, 1);
    checkOutput("reset ld_ready", ld_ready, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset flags", {done, timeout, overflow}, 0);
    checkOutput("reset wdog_cnt", wdog_cnt, 0);
    checkOutput("reset write ports", {im_we, dm_we, im_addr, dm_addr}, 0);
    rst = 1'b0;
    tick;

    // Basic load of four words, INIT scrub, then RUN six cycles after last accept.
    pulseStart;
    checkOutput("ld_ready after start", ld_ready, 1);
    checkOutput("busy in load", busy, 1);
    applyStimulus(1'b1, 32'h11, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0);
    applyStimulus(1'b1, 32'h33, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b1);
    pushInit;
    checkOutput("ld_ready in init", ld_ready, 0);
    repeat (4) tick;
    checkOutput("cpu_rst last init cycle", cpu_rst, 1);
    tick;
    checkOutput("cpu_rst in run", cpu_rst, 0);
    checkOutput("wdog_cnt run entry", wdog_cnt, 0);

    // Completion: near-miss stores pass through, the real flag ends the run.
    applyStore(4'h1, 16'hfffc, 32'h000000FE);
    checkOutput("done after 0xFE store", done, 0);
    applyStore(4'h1, 16'hfff8, 32'h000000FF);
    checkOutput("done after 0xfff8 store", done, 0);
    checkOutput("cpu_rst still running", cpu_rst, 0);
    applyStore(4'h1, 16'hfffc, 32'h000000FF);
    checkOutput("done after flag", done, 1);
    checkOutput("cpu_rst after flag", cpu_rst, 1);
    checkOutput("busy after flag", busy, 0);
    checkOutput("wdog_cnt held in done", wdog_cnt, 3);
    cpu_dm_we = 4'hF;
    cpu_dm_addr = 16'h1234;
    #1 checkOutput("dm_we gated in done", dm_we, 0);
    cpu_dm_we = 4'h0;
    cpu_dm_addr = 16'h0;

    // Restart from DONE with a throttled load.
    tick;
    pulseStart;
    checkOutput("done cleared on restart", done, 0);
    checkOutput("wdog cleared on restart", wdog_cnt, 0);
    checkOutput("ld_ready on restart", ld_ready, 1);
    applyStimulus(1'b1, 32'hA0, 1'b0);
    applyStimulus(1'b0, 32'hBAD0, 1'b0);
    applyStimulus(1'b1, 32'hA1, 1'b0);
    applyStimulus(1'b0, 32'hBAD1, 1'b0);
    applyStimulus(1'b1, 32'hA2, 1'b1);
    pushInit;
    repeat (5) tick;
    checkOutput("cpu_rst run after backpressure", cpu_rst, 0);

    // Watchdog expiry exactly WMAX cycles after RUN entry.
    repeat (WMAX - 1) tick;
    checkOutput("timeout before limit", timeout, 0);
    checkOutput("wdog_cnt at limit-1", wdog_cnt, WMAX - 1);
    tick;
    checkOutput("timeout at limit", timeout, 1);
    checkOutput("done on timeout", done, 0);
    checkOutput("cpu_rst on timeout", cpu_rst, 1);

    // Flag store on the final watchdog cycle: DONE wins.
    pulseStart;
    checkOutput("timeout cleared on restart", timeout, 0);
    applyStimulus(1'b1, 32'h55, 1'b1);
    pushInit;
    repeat (5) tick;
    repeat (WMAX - 1) tick;
    applyStore(4'h1, 16'hfffc, 32'h123456FF);
    checkOutput("done on tie", done, 1);
    checkOutput("timeout on tie", timeout, 0);

    // Asynchronous reset during RUN.
    pulseStart;
    applyStimulus(1'b1, 32'h66, 1'b1);
    pushInit;
    repeat (5) tick;
    checkOutput("cpu_rst before reset", cpu_rst, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("cpu_rst on reset in run", cpu_rst, 1);
    checkOutput("ld_ready on reset in run", ld_ready, 0);
    checkOutput("busy on reset in run", busy, 0);
    checkOutput("wdog_cnt on reset in run", wdog_cnt, 0);
    tick;
    rst = 1'b0;
    tick;

    // Asynchronous reset during LOAD; the third word must never be written.
    pulseStart;
    applyStimulus(1'b1, 32'h77, 1'b0);
    applyStimulus(1'b1, 32'h78, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 32'h79;
    #1 rst = 1'b1;
    #1;
    checkOutput("ld_ready on reset in load", ld_ready, 0);
    checkOutput("cpu_rst on reset in load", cpu_rst, 1);
    checkOutput("im_we on reset in load", im_we, 0);
    ld_valid = 1'b0;
    tick;
    rst = 1'b0;
    tick;

    // Fresh load restarts at address zero; start is ignored while running.
    pulseStart;
    applyStimulus(1'b1, 32'h88, 1'b1);
    pushInit;
    repeat (5) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("start ignored in run", {busy, cpu_rst}, 2'b10);
    applyStore(4'hF, 16'hfffc, 32'h000000FF);
    checkOutput("done before overflow test", done, 1);

    // Overflow: a full image without ld_last ends at the top word.
    pulseStart;
    checkOutput("overflow cleared", overflow, 0);
    for (int i = 0; i < 16384; i++) begin
      applyStimulus(1'b1, 32'h1000_0000 + (i * 7), 1'b0);
    end
    pushInit;
    checkOutput("overflow set", overflow, 1);
    checkOutput("ld_ready after overflow", ld_ready, 0);
    checkOutput("busy in init after overflow", busy, 1);
    repeat (4) tick;
    checkOutput("cpu_rst init after overflow", cpu_rst, 1);
    tick;
    checkOutput("cpu_rst run after overflow", cpu_rst, 0);
    repeat (3) tick;

    checkOutput("scoreboard drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
